// File: rtl/lock_timing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lock_timing_pkg
//  Description : Shared timing definitions for the combination-lock timing
//                path: controller state encoding, system clock constant and
//                the prescale helper used by every tick-based block.
//  Revision    : 1.0  initial release
// ============================================================================
package lock_timing_pkg;

    // System clock frequency of the lock board
    localparam int unsigned c_CLK_HZ = 50_000_000;

    // Countdown controller states, explicitly encoded
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } timer_state_t;

    // Clock cycles per tick; a zero tick rate yields 0 so callers can flag it
    function automatic int unsigned calc_prescale(input int unsigned clk_hz,
                                                  input int unsigned tick_hz);
        if (tick_hz == 0) begin
            return 0;
        end
        return clk_hz / tick_hz;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Modulo-PRESCALE counter producing a one-cycle enable tick at
//                terminal count while enabled. clr holds the count at zero.
//  Revision    : 1.0  initial release
// ============================================================================
module tick_prescaler #(
    parameter int unsigned PRESCALE = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned     c_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_W-1:0]  c_TERM = c_W'(PRESCALE - 1);
    localparam logic [c_W-1:0]  c_ONE  = c_W'(1);

    logic [c_W-1:0] r_cnt;

    // Count while enabled, wrap at terminal count, clear has priority
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (r_cnt == c_TERM) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + c_ONE;
            end
        end
    end

    assign tick = en && (r_cnt == c_TERM);

endmodule
`default_nettype wire

// File: rtl/lock_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : lock_timer_ctrl
//  Description : Timeout controller for the lock timing path. Runs one
//                programmable countdown per start request using a
//                start/busy/done handshake and exports the tick as a clock
//                enable for display blinking.
//  Revision    : 1.0  initial release
// ============================================================================
module lock_timer_ctrl
    import lock_timing_pkg::*;
#(
    parameter int unsigned CLK_HZ  = c_CLK_HZ,
    parameter int unsigned TICK_HZ = 1000,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] duration,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] remaining,
    output logic             tick_out
);

    localparam int unsigned      c_PRESCALE = calc_prescale(CLK_HZ, TICK_HZ);
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    if (c_PRESCALE < 2) begin : g_bad_prescale
        $error("lock_timer_ctrl: CLK_HZ/TICK_HZ must be at least 2");
    end

    timer_state_t     r_state;
    timer_state_t     w_state_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_remaining_nxt;
    logic             w_run;
    logic             w_tick;
    logic             w_presc_clr;

    assign w_run = (r_state == ST_RUN);

    // Prescaler only advances in RUN; any other state or a cancel re-aligns it
    assign w_presc_clr = !w_run || cancel;

    tick_prescaler #(
        .PRESCALE (c_PRESCALE)
    ) u_tick_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_presc_clr),
        .en   (w_run),
        .tick (w_tick)
    );

    // State and remaining-count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    // Next-state and remaining-count decode; cancel outranks tick and expiry
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        case (r_state)
            ST_IDLE: begin
                if (!cancel && start) begin
                    w_remaining_nxt = duration;
                    if (duration == '0) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    w_state_nxt     = ST_IDLE;
                    w_remaining_nxt = '0;
                end else if (w_tick) begin
                    w_remaining_nxt = r_remaining - c_ONE;
                    if (r_remaining == c_ONE) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_remaining_nxt = '0;
            end
        endcase
    end

    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);
    assign remaining = r_remaining;
    assign tick_out  = w_run && w_tick;

endmodule
`default_nettype wire

// File: tb/tb_lock_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lock_timer_ctrl
//  Description : Self-checking bench for lock_timer_ctrl with PRESCALE=10 and
//                a narrow counter so the maximum duration is reachable.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lock_timer_ctrl;

    localparam int unsigned c_P     = 10;
    localparam int unsigned c_CNT_W = 4;
    localparam int unsigned c_MAXD  = (1 << c_CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [c_CNT_W-1:0] duration;
    logic               cancel;
    logic               busy;
    logic               done;
    logic [c_CNT_W-1:0] remaining;
    logic               tick_out;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: a countdown is "edges elapsed since acceptance" against N*P
    bit          m_active;
    bit          m_done;
    int unsigned m_elapsed;
    int unsigned m_n;

    int unsigned done_at;
    int unsigned done_cnt;
    int unsigned tick_cnt;

    lock_timer_ctrl #(
        .CLK_HZ  (10),
        .TICK_HZ (1),
        .CNT_W   (c_CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .duration  (duration),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .remaining (remaining),
        .tick_out  (tick_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Advance the reference by one clock edge using the applied inputs
    task automatic model_edge(input bit r, input bit s, input bit c, input int unsigned d);
        if (r) begin
            m_active = 0; m_done = 0; m_elapsed = 0; m_n = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_active) begin
            if (c) begin
                m_active = 0;
            end else begin
                m_elapsed++;
                if (m_elapsed == m_n * c_P) begin
                    m_active = 0;
                    m_done   = 1;
                end
            end
        end else if (!c && s) begin
            if (d == 0) begin
                m_done = 1;
            end else begin
                m_active = 1; m_elapsed = 0; m_n = d;
            end
        end
    endtask

    // Apply inputs for one cycle, clock it, then compare all outputs mid-cycle
    task automatic step(input bit r, input bit s, input bit c, input int unsigned d);
        int unsigned exp_rem;
        bit          exp_tick;
        rst = r; start = s; cancel = c; duration = c_CNT_W'(d);
        @(posedge clk);
        model_edge(r, s, c, d);
        @(negedge clk);
        exp_rem  = m_active ? (m_n - m_elapsed / c_P) : 0;
        exp_tick = m_active && ((m_elapsed % c_P) == c_P - 1);
        chk("busy",      busy,      m_active || m_done);
        chk("done",      done,      m_done);
        chk("remaining", remaining, exp_rem);
        chk("tick_out",  tick_out,  exp_tick);
        if (done)     done_cnt++;
        if (tick_out) tick_cnt++;
    endtask

    task automatic idle(input int unsigned n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        rst = 1; start = 0; cancel = 0; duration = '0;
        m_active = 0; m_done = 0; m_elapsed = 0; m_n = 0;

        // Reset held with start asserted
        for (int i = 0; i < 3; i++) step(1, 1, 0, 5);
        idle(2);

        // Nominal countdown of 3 ticks: done observed after edge 30
        done_at = 0; done_cnt = 0; tick_cnt = 0;
        step(0, 1, 0, 3);
        for (int k = 1; k <= 35; k++) begin
            step(0, 0, 0, 0);
            if (done && done_at == 0) done_at = k;
        end
        chk("t2_done_at",   done_at,  30);
        chk("t2_done_cnt",  done_cnt, 1);
        chk("t2_tick_cnt",  tick_cnt, 3);

        // Zero duration: immediate done, no ticks
        done_cnt = 0; tick_cnt = 0;
        step(0, 1, 0, 0);
        chk("t3_done_now", done, 1);
        idle(15);
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_tick_cnt", tick_cnt, 0);

        // Cancel at edge 15, then a 1-tick countdown
        done_cnt = 0;
        step(0, 1, 0, 3);
        idle(14);
        step(0, 0, 1, 0);
        idle(25);
        chk("t4_no_done", done_cnt, 0);
        step(0, 1, 0, 1);
        idle(12);
        chk("t4_short_done", done_cnt, 1);

        // Start while busy is ignored
        done_at = 0;
        step(0, 1, 0, 3);
        idle(11);
        step(0, 1, 0, 7);
        for (int k = 13; k <= 35; k++) begin
            step(0, 0, 0, 0);
            if (done && done_at == 0) done_at = k;
        end
        chk("t5_done_at", done_at, 30);

        // Reset mid-run, then a phase-aligned 2-tick countdown
        step(0, 1, 0, 3);
        idle(16);
        step(1, 0, 0, 0);
        done_at = 0;
        step(0, 1, 0, 2);
        for (int k = 1; k <= 25; k++) begin
            step(0, 0, 0, 0);
            if (done && done_at == 0) done_at = k;
        end
        chk("t6_done_at", done_at, 20);

        // Cancel coincident with the expiring tick
        done_cnt = 0;
        step(0, 1, 0, 1);
        idle(9);
        step(0, 0, 1, 0);
        idle(3);
        chk("cancel_at_expiry", done_cnt, 0);

        // Maximum duration, no wrap
        done_at = 0;
        step(0, 1, 0, c_MAXD);
        for (int k = 1; k <= c_MAXD * c_P + 3; k++) begin
            step(0, 0, 0, 0);
            if (done && done_at == 0) done_at = k;
        end
        chk("max_done_at", done_at, c_MAXD * c_P);

        // Randomized traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            bit          r, s, c;
            int unsigned d, sel;
            r   = ($urandom_range(0, 199) == 0);
            s   = ($urandom_range(0, 3) == 0);
            c   = ($urandom_range(0, 39) == 0);
            sel = $urandom_range(0, 9);
            d   = (sel == 0) ? 0 : (sel == 1) ? c_MAXD : $urandom_range(1, 4);
            step(r, s, c, d);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
